// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: frames serial bits into WIDTH-bit words and
// presents each completed word on a held register with a Valid/Ready handshake.
module shift_deser #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             InS,
  input  logic             BitEn,
  input  logic             Frame,
  input  logic             RL,
  input  logic             Ready,
  output logic [WIDTH-1:0] OutP,
  output logic             Valid,
  output logic             Busy,
  output logic             Overrun,
  output logic             FrameErr,
  output logic             dbg_state_o
);

  // Handshake: OutP is offered while Valid=1 and is consumed on any rising
  // edge where Valid & Ready; Valid never drops without Ready, and OutP only
  // changes while Valid=1 when a new word completes on an accepting edge.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] outp_q, outp_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] sr_in;
  logic             complete;

  always_ff @(posedge CLK) begin
    if (Clear) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      outp_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      outp_q      <= outp_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    sr_in       = RL ? {sr_q[WIDTH-2:0], InS} : {InS, sr_q[WIDTH-1:1]};
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;
    case (state_q)
      IDLE: begin
        if (BitEn && Frame) begin
          sr_d    = sr_in;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (BitEn) begin
          sr_d = sr_in;
          if (Frame) begin
            // Mid-word Frame restarts the word with this bit as its first.
            frame_err_d = 1'b1;
            cnt_d       = CW'(1);
          end else if (cnt_q == LAST_CNT) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outp_d    = outp_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (complete) begin
      if (!valid_q || Ready) begin
        outp_d  = sr_in;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && Ready) begin
      valid_d = 1'b0;
    end
  end

  assign OutP        = outp_q;
  assign Valid       = valid_q;
  assign Busy        = (state_q == SHIFT);
  assign Overrun     = overrun_q;
  assign FrameErr    = frame_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: directed handshake/overrun/framing cases plus random
// words with random gaps, checked against a scoreboard of expected words.
module tb_shift_deser;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         Clear = 1'b1;
  logic         InS = 1'b0;
  logic         BitEn = 1'b0;
  logic         Frame = 1'b0;
  logic         RL = 1'b0;
  logic         Ready = 1'b0;
  logic [W-1:0] OutP;
  logic         Valid;
  logic         Busy;
  logic         Overrun;
  logic         FrameErr;
  logic         dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           busy_cnt = 0;
  int           valid_cnt = 0;
  int           fe_cnt = 0;
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [W-1:0] prev_outp = '0;

  shift_deser #(.WIDTH(W)) dut (
    .CLK(CLK), .Clear(Clear), .InS(InS), .BitEn(BitEn), .Frame(Frame),
    .RL(RL), .Ready(Ready), .OutP(OutP), .Valid(Valid), .Busy(Busy),
    .Overrun(Overrun), .FrameErr(FrameErr), .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // First bit carries Frame; RL=0 sends word[0] first, RL=1 sends word[W-1] first.
  task automatic send_bits(input logic [W-1:0] w, input logic rl, input int n,
                           input int gmax, input int last_ready, input bit rand_ready);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, gmax);
      for (int g = 0; g < gap; g++) begin
        if (rand_ready) Ready = 1'($urandom_range(0, 1));
        tick();
      end
      BitEn = 1'b1;
      Frame = (i == 0);
      RL    = rl;
      InS   = rl ? w[W-1-i] : w[i];
      if (rand_ready) Ready = 1'($urandom_range(0, 1));
      if (i == n - 1 && last_ready >= 0) Ready = 1'(last_ready);
      tick();
      BitEn = 1'b0;
      Frame = 1'b0;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rl, input int gmax,
                           input int last_ready);
    send_bits(w, rl, W, gmax, last_ready, 1'b0);
  endtask

  // Output monitor: a newly presented word is popped from the scoreboard;
  // a held word must not change.
  always @(negedge CLK) begin
    if (Valid) begin
      if (!prev_valid || prev_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_word", 32'(OutP), 32'hFFFF);
        else chk("sb_word", 32'(OutP), 32'(exp_q.pop_front()));
      end else begin
        chk("hold_outp", 32'(OutP), 32'(prev_outp));
      end
    end
    busy_cnt  += int'(Busy);
    valid_cnt += int'(Valid);
    fe_cnt    += int'(FrameErr);
    prev_valid = Valid;
    prev_ready = Ready;
    prev_outp  = OutP;
  end

  initial begin
    tick();
    tick();
    chk("rst_outp", 32'(OutP), 0);
    chk("rst_valid", 32'(Valid), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_overrun", 32'(Overrun), 0);
    chk("rst_frameerr", 32'(FrameErr), 0);
    Clear = 1'b0;
    tick();

    // 1: LSB-first, Ready=1, no gaps
    Ready = 1'b1;
    busy_cnt = 0;
    valid_cnt = 0;
    exp_q.push_back(4'b1101);
    send_word(4'b1101, 1'b0, 0, -1);
    repeat (3) tick();
    chk("t1_busy_cycles", busy_cnt, 3);
    chk("t1_valid_cycles", valid_cnt, 1);

    // 2: MSB-first held while Ready=0
    Ready = 1'b0;
    exp_q.push_back(4'b1011);
    send_word(4'b1011, 1'b1, 0, -1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2_valid_hold", 32'(Valid), 1);
    end
    Ready = 1'b1;
    tick();
    chk("t2_valid_drop", 32'(Valid), 0);

    // 3: overrun, sticky until Clear
    Ready = 1'b0;
    exp_q.push_back(4'h5);
    send_word(4'h5, 1'b0, 2, -1);
    send_word(4'hA, 1'b0, 2, -1);
    chk("t3_outp_kept", 32'(OutP), 32'h5);
    chk("t3_overrun", 32'(Overrun), 1);
    repeat (5) tick();
    Ready = 1'b1;
    repeat (2) tick();
    chk("t3_overrun_sticky", 32'(Overrun), 1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("t3_overrun_clr", 32'(Overrun), 0);

    // 4: accept and complete on the same edge
    Ready = 1'b0;
    exp_q.push_back(4'h3);
    send_word(4'h3, 1'b1, 1, -1);
    exp_q.push_back(4'hC);
    send_word(4'hC, 1'b1, 1, 1);
    chk("t4_outp", 32'(OutP), 32'hC);
    chk("t4_valid", 32'(Valid), 1);
    chk("t4_overrun", 32'(Overrun), 0);
    repeat (2) tick();

    // 5: Frame mid-word restarts the word
    Ready = 1'b1;
    send_bits(4'h6, 1'b0, 2, 0, -1, 1'b0);
    fe_cnt = 0;
    exp_q.push_back(4'h9);
    send_word(4'h9, 1'b1, 2, -1);
    repeat (2) tick();
    chk("t5_frameerr_pulses", fe_cnt, 1);
    chk("t5_valid_done", 32'(Valid), 0);

    // 6: Clear mid-word with a held word
    Ready = 1'b0;
    exp_q.push_back(4'h6);
    send_word(4'h6, 1'b0, 3, -1);
    send_bits(4'hF, 1'b0, 3, 3, -1, 1'b0);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("t6_outp", 32'(OutP), 0);
    chk("t6_valid", 32'(Valid), 0);
    chk("t6_busy", 32'(Busy), 0);
    chk("t6_overrun", 32'(Overrun), 0);
    chk("t6_frameerr", 32'(FrameErr), 0);
    Ready = 1'b1;
    exp_q.push_back(4'hB);
    send_word(4'hB, 1'b0, 5, -1);
    repeat (2) tick();

    // random words, random gaps and Ready, accepted on completion
    for (int r = 0; r < 16; r++) begin
      logic [W-1:0] w;
      logic         rl;
      w  = W'($urandom_range(0, 15));
      rl = 1'($urandom_range(0, 1));
      exp_q.push_back(w);
      send_bits(w, rl, W, 5, 1, 1'b1);
    end
    Ready = 1'b1;
    repeat (3) tick();
    chk("rand_overrun", 32'(Overrun), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
